mux_oh: RTL and testbench

One-hot-select multiplexer with a registered output stage, used wherever an arbiter or decoder grant picks one of several equal-width data lanes. It takes `InputWidth` lanes of `DataWidth` bits and a one-hot select vector. It returns the selected lane one clock later, with a valid qualifier and an optional one-hot violation flag.

---
 rtl/mux_oh.sv | 79 +++++++
 tb/tb_mux_oh.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux_oh.sv
// One-hot-select AND-OR multiplexer with a registered output stage.
// Define MUX_OH_CHECK_EN to build the one-hot detector and the err_o register.

module mux_oh_lane #(
    parameter int DataWidth = 8
) (
    input  logic                 sel,
    input  logic [DataWidth-1:0] data,
    output logic [DataWidth-1:0] gated
);
    assign gated = data & {DataWidth{sel}};
endmodule

module mux_oh #(
    parameter int InputWidth = 8,
    parameter int DataWidth  = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 valid_i,
    input  logic [InputWidth-1:0]                sel_i,
    input  logic [InputWidth-1:0][DataWidth-1:0] data_i,
    output logic                                 valid_o,
    output logic [DataWidth-1:0]                 data_o,
    output logic                                 err_o
);
    logic [InputWidth-1:0][DataWidth-1:0] gated;
    logic [DataWidth-1:0]                 mux;

    for (genvar g = 0; g < InputWidth; g++) begin : g_lane
        mux_oh_lane #(.DataWidth(DataWidth)) u_lane (
            .sel   (sel_i[g]),
            .data  (data_i[g]),
            .gated (gated[g])
        );
    end

    // Plain OR of gated lanes: multi-hot selects yield the OR of those lanes.
    always_comb begin
        mux = '0;
        for (int i = 0; i < InputWidth; i++) begin
            mux = mux | gated[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                data_o <= mux;
            end
        end
    end

`ifdef MUX_OH_CHECK_EN
    logic onehot;
    assign onehot = (sel_i != '0) && ((sel_i & (sel_i - InputWidth'(1))) == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else begin
            err_o <= valid_i & ~onehot;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && valid_i) begin
            assert (onehot) else $error("mux_oh: sel_i not one-hot: %b", sel_i);
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mux_oh.sv
// Randomized self-checking bench for mux_oh with a behavioural reference model.
// Expected err_o follows whether MUX_OH_CHECK_EN is defined for the build.

module tb_mux_oh;
    localparam int IW = 8;
    localparam int DW = 8;
`ifdef MUX_OH_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_ni;
    logic                   valid_i;
    logic [IW-1:0]          sel_i;
    logic [IW-1:0][DW-1:0]  data_i;
    logic                   valid_o;
    logic [DW-1:0]          data_o;
    logic                   err_o;

    int checks = 0;
    int failures = 0;

    mux_oh #(.InputWidth(IW), .DataWidth(DW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .sel_i   (sel_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    // Reference model: what the outputs must be after each edge.
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_err;
    bit            m_known = 1'b0;

    always @(posedge clk) begin
        if (!rst_ni) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
        end else if (valid_i) begin
            m_data = '0;
            for (int k = 0; k < IW; k++)
                if (sel_i[k]) m_data = m_data | data_i[k];
            m_valid = 1'b1;
            m_err   = CHK && ($countones(sel_i) != 1);
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
        end
        m_known = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            chk("model_valid", 32'(valid_o), 32'(m_valid));
            chk("model_data",  32'(data_o),  32'(m_data));
            chk("model_err",   32'(err_o),   32'(m_err));
        end
    end

    task automatic rand_lanes();
        for (int k = 0; k < IW; k++) data_i[k] = DW'($urandom_range(0, 255));
    endtask

    // Apply inputs, take one edge, return just after it.
    task automatic cyc(input logic r, input logic v, input logic [IW-1:0] s);
        rst_ni  = r;
        valid_i = v;
        sel_i   = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; sel_i = '0; data_i = '0;

        // Reset with valid inputs present
        for (int n = 0; n < 2; n++) begin
            rand_lanes();
            cyc(1'b0, 1'b1, IW'(1) << $urandom_range(0, IW-1));
            chk("rst_valid", 32'(valid_o), 32'h0);
            chk("rst_data",  32'(data_o),  32'h0);
            chk("rst_err",   32'(err_o),   32'h0);
        end

        // Random one-hot sweep
        for (int n = 0; n < 10000; n++) begin
            rand_lanes();
            cyc(1'b1, 1'b1, IW'(1) << $urandom_range(0, IW-1));
        end

        // Hold
        rand_lanes();
        data_i[2] = 8'hA5;
        cyc(1'b1, 1'b1, 8'b0000_0100);
        chk("hold_accept", 32'(data_o), 32'hA5);
        for (int n = 0; n < 3; n++) begin
            rand_lanes();
            cyc(1'b1, 1'b0, 8'($urandom_range(0, 255)));
            chk("hold_data",  32'(data_o),  32'hA5);
            chk("hold_valid", 32'(valid_o), 32'h0);
        end

        // Zero select
        rand_lanes();
        cyc(1'b1, 1'b1, 8'h00);
        chk("zero_data", 32'(data_o), 32'h00);
        chk("zero_err",  32'(err_o),  32'(CHK));

        // Multi-hot
        rand_lanes();
        data_i[0] = 8'h0F;
        data_i[1] = 8'hF0;
        cyc(1'b1, 1'b1, 8'b0000_0011);
        chk("multi_data",  32'(data_o),  32'hFF);
        chk("multi_err",   32'(err_o),   32'(CHK));
        chk("multi_valid", 32'(valid_o), 32'h1);

        // Mid-stream reset
        for (int n = 0; n < 5; n++) begin
            rand_lanes();
            cyc(1'b1, 1'b1, IW'(1) << $urandom_range(0, IW-1));
        end
        rand_lanes();
        cyc(1'b0, 1'b1, 8'h10);
        chk("mid_rst_valid", 32'(valid_o), 32'h0);
        chk("mid_rst_data",  32'(data_o),  32'h0);
        rand_lanes();
        data_i[3] = 8'h3C;
        cyc(1'b1, 1'b1, 8'b0000_1000);
        chk("resume_valid", 32'(valid_o), 32'h1);
        chk("resume_data",  32'(data_o),  32'h3C);

        // Select range edges, back to back
        rand_lanes();
        data_i[7] = 8'h81;
        cyc(1'b1, 1'b1, 8'b1000_0000);
        chk("edge_hi", 32'(data_o), 32'h81);
        rand_lanes();
        data_i[0] = 8'h7E;
        cyc(1'b1, 1'b1, 8'b0000_0001);
        chk("edge_lo",    32'(data_o),  32'h7E);
        chk("edge_valid", 32'(valid_o), 32'h1);
        chk("edge_err",   32'(err_o),   32'h0);

        // Fully random mix (one-hot, zero, multi-hot, idle, occasional reset)
        for (int n = 0; n < 3000; n++) begin
            rand_lanes();
            cyc(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? (IW'(1) << $urandom_range(0, IW-1))
                                            : 8'($urandom_range(0, 255)));
        end

        valid_i = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
